// File: rtl/instr_dcd_burst.sv
// instr_dcd_burst: SPI byte-stream command decoder producing register read/write strobes with burst auto-increment
module instr_dcd_burst #(
  parameter int ADDR_W = 6,
  parameter int DATA_BYTES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs_active,
  input  logic                      byte_sync,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic [8*DATA_BYTES-1:0]   data_read,
  output logic                      read,
  output logic                      write,
  output logic [ADDR_W-1:0]         addr,
  output logic [8*DATA_BYTES-1:0]   data_write,
  output logic                      busy,
  output logic                      frame_err
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int SH = 14 - ADDR_W;
  localparam int LO = ADDR_W > 6 ? ADDR_W - 6 : 0;
  localparam logic [13:0] LO_MASK = 14'((1 << LO) - 1);
  localparam logic [1:0] LAST = 2'(DATA_BYTES - 1);
  typedef enum logic [2:0] {HDR0, HDR1, WDATA, RLOAD, RDATA} state_t;
  state_t state, state_nxt;
  logic rw, burst, hold;
  logic [5:0] hi;
  logic [1:0] byte_cnt;
  logic [DW-1:0] shreg, rd_word, word_in;
  logic [DW+7:0] cat;
  logic [4:0] sh;
  logic last;
  assign busy = state != HDR0;
  assign last = byte_cnt == LAST;
  assign cat = {shreg, data_in};
  assign word_in = cat[DW-1:0];
  assign sh = {LAST - byte_cnt - 2'd1, 3'b000};
  always_comb begin
    state_nxt = state;
    if (!cs_active) state_nxt = HDR0;
    else case (state)
      HDR0:  if (byte_sync && !hold) state_nxt = ADDR_W > 6 ? HDR1 : (data_in[7] ? WDATA : RLOAD);
      HDR1:  if (byte_sync) state_nxt = rw ? WDATA : RLOAD;
      WDATA: if (byte_sync && last && !burst) state_nxt = HDR0;
      RLOAD: state_nxt = byte_sync ? HDR0 : RDATA;
      RDATA: if (byte_sync && last) state_nxt = burst ? RLOAD : HDR0;
      default: state_nxt = HDR0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR0;
      rw <= 1'b0;
      burst <= 1'b0;
      hold <= 1'b0;
      hi <= '0;
      byte_cnt <= '0;
      shreg <= '0;
      rd_word <= '0;
      addr <= '0;
      data_write <= '0;
      data_out <= '0;
      read <= 1'b0;
      write <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;
      read <= 1'b0;
      write <= 1'b0;
      frame_err <= 1'b0;
      if (write && burst) addr <= addr + 1'b1;
      if (!cs_active) begin
        byte_cnt <= '0;
        data_out <= '0;
        hold <= 1'b0;
        frame_err <= state == WDATA && byte_cnt != 2'd0;
      end else case (state)
        HDR0: if (byte_sync && !hold) begin
          rw <= data_in[7];
          burst <= data_in[6];
          hi <= data_in[5:0];
          byte_cnt <= '0;
          if (ADDR_W <= 6) addr <= ADDR_W'(data_in[5:0]);
          read <= ADDR_W <= 6 && !data_in[7];
        end
        HDR1: if (byte_sync) begin
          addr <= ADDR_W'(({hi, 8'h00} >> SH) | (14'(data_in) & LO_MASK));
          read <= !rw;
        end
        WDATA: if (byte_sync) begin
          shreg <= word_in;
          byte_cnt <= last ? 2'd0 : byte_cnt + 2'd1;
          if (last) begin
            write <= 1'b1;
            data_write <= word_in;
            hold <= !burst;
          end
        end
        RLOAD: if (byte_sync) begin
          frame_err <= 1'b1;
          data_out <= '0;
          hold <= 1'b1;
        end else begin
          rd_word <= data_read;
          data_out <= data_read[DW-1 -: 8];
          byte_cnt <= '0;
        end
        RDATA: if (byte_sync) begin
          // non-last bytes advance the MSB-first byte pointer into the held word
          byte_cnt <= last ? 2'd0 : byte_cnt + 2'd1;
          if (!last) data_out <= 8'(rd_word >> sh);
          else if (burst) begin
            addr <= addr + 1'b1;
            read <= 1'b1;
          end else begin
            data_out <= '0;
            hold <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_dcd_burst.sv
// tb_instr_dcd_burst: directed checks on default, 2-byte-word and 10-bit-address decoder instances
module tb_instr_dcd_burst;
  logic clk = 1'b0, rst = 1'b1, cs_active = 1'b0, byte_sync = 1'b0;
  logic [7:0] data_in = '0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;

  logic [7:0] a_do, a_dr = '0, a_dw;
  logic a_rd, a_wr, a_busy, a_fe;
  logic [5:0] a_addr;
  instr_dcd_burst dut_a (.clk(clk), .rst(rst), .cs_active(cs_active), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(a_do), .data_read(a_dr), .read(a_rd), .write(a_wr),
    .addr(a_addr), .data_write(a_dw), .busy(a_busy), .frame_err(a_fe));

  logic [7:0] b_do;
  logic [15:0] b_dr, b_dw;
  logic b_rd, b_wr, b_busy, b_fe;
  logic [5:0] b_addr;
  assign b_dr = 16'h0;
  instr_dcd_burst #(.ADDR_W(6), .DATA_BYTES(2)) dut_b (.clk(clk), .rst(rst), .cs_active(cs_active),
    .byte_sync(byte_sync), .data_in(data_in), .data_out(b_do), .data_read(b_dr), .read(b_rd),
    .write(b_wr), .addr(b_addr), .data_write(b_dw), .busy(b_busy), .frame_err(b_fe));

  logic [7:0] c_do, c_dr, c_dw;
  logic c_rd, c_wr, c_busy, c_fe;
  logic [9:0] c_addr;
  assign c_dr = 8'(c_addr * 3);
  instr_dcd_burst #(.ADDR_W(10), .DATA_BYTES(1)) dut_c (.clk(clk), .rst(rst), .cs_active(cs_active),
    .byte_sync(byte_sync), .data_in(data_in), .data_out(c_do), .data_read(c_dr), .read(c_rd),
    .write(c_wr), .addr(c_addr), .data_write(c_dw), .busy(c_busy), .frame_err(c_fe));

  int a_wn, a_rn, b_wn, b_fen, c_rn, both;
  logic [5:0] a_waddr, a_raddr;
  logic [7:0] a_wdata;
  logic [5:0] b_wa[$];
  logic [15:0] b_wd[$];
  logic [9:0] c_ra[$];

  always @(negedge clk) begin
    if (a_wr) begin a_wn++; a_waddr = a_addr; a_wdata = a_dw; end
    if (a_rd) begin a_rn++; a_raddr = a_addr; end
    if (b_wr) begin b_wn++; b_wa.push_back(b_addr); b_wd.push_back(b_dw); end
    if (b_fe) b_fen++;
    if (c_rd) begin c_rn++; c_ra.push_back(c_addr); end
    if ((a_rd && a_wr) || (b_rd && b_wr) || (c_rd && c_wr)) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    a_wn = 0; a_rn = 0; b_wn = 0; b_fen = 0; c_rn = 0;
    b_wa.delete(); b_wd.delete(); c_ra.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    byte_sync = 1'b1;
    @(negedge clk);
    byte_sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs_active = 1'b0;
    repeat (3) @(negedge clk);
    clr();
    cs_active = 1'b1;
  endtask

  initial begin
    both = 0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_read", a_rd, 0);
    chk("rst_write", a_wr, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_dout", a_do, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ferr", b_fe, 0);
    rst = 1'b0;
    @(negedge clk);
    cs_active = 1'b1;
    // T1: single write
    send(8'h93);
    chk("t1_busy_mid", a_busy, 1);
    send(8'hA6);
    chk("t1_wn", a_wn, 1);
    chk("t1_waddr", a_waddr, 6'h13);
    chk("t1_wdata", a_wdata, 8'hA6);
    chk("t1_rn", a_rn, 0);
    chk("t1_busy_end", a_busy, 0);
    end_frame();
    // T2: single read, trailing bytes ignored
    a_dr = 8'hEE;
    send(8'h01);
    chk("t2_rn", a_rn, 1);
    chk("t2_raddr", a_raddr, 6'h01);
    chk("t2_dout", a_do, 8'hEE);
    chk("t2_busy", a_busy, 1);
    send(8'hFF);
    chk("t2_dout_end", a_do, 0);
    chk("t2_busy_end", a_busy, 0);
    send(8'h93);
    chk("t2_ignored_wn", a_wn, 0);
    chk("t2_rn_end", a_rn, 1);
    end_frame();
    // T3: 2-byte burst write
    send(8'hC3); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("t3_wn", b_wn, 2);
    chk("t3_wa0", b_wa[0], 6'h03);
    chk("t3_wd0", b_wd[0], 16'h1234);
    chk("t3_wa1", b_wa[1], 6'h04);
    chk("t3_wd1", b_wd[1], 16'h5678);
    chk("t3_addr_next", b_addr, 6'h05);
    chk("t3_busy", b_busy, 1);
    @(negedge clk);
    cs_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_no_ferr", b_fen, 0);
    clr();
    cs_active = 1'b1;
    // T4: 10-bit burst read wrapping at max address
    send(8'h7F); send(8'h0F);
    chk("t4_rn0", c_rn, 1);
    chk("t4_ra0", c_ra[0], 10'h3FF);
    chk("t4_dout0", c_do, 8'hFD);
    send(8'h00);
    chk("t4_ra1", c_ra[1], 10'h000);
    chk("t4_dout1", c_do, 8'h00);
    send(8'h00);
    chk("t4_rn2", c_rn, 3);
    chk("t4_ra2", c_ra[2], 10'h001);
    chk("t4_dout2", c_do, 8'h03);
    end_frame();
    // T5: partial write aborted by cs_active
    send(8'h85); send(8'hAB);
    chk("t5_busy_mid", b_busy, 1);
    @(negedge clk);
    cs_active = 1'b0;
    @(negedge clk);
    chk("t5_ferr", b_fe, 1);
    chk("t5_busy", b_busy, 0);
    @(negedge clk);
    chk("t5_ferr_pulse", b_fe, 0);
    chk("t5_wn", b_wn, 0);
    chk("t5_fen", b_fen, 1);
    clr();
    cs_active = 1'b1;
    // T6: reset mid-word, then a clean frame
    send(8'h81); send(8'h11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", b_busy, 0);
    chk("t6_addr", b_addr, 0);
    chk("t6_dout", b_do, 0);
    chk("t6_write", b_wr, 0);
    chk("t6_read", b_rd, 0);
    clr();
    send(8'h81); send(8'h11); send(8'h22);
    chk("t6_wn", b_wn, 1);
    chk("t6_wa", b_wa[0], 6'h01);
    chk("t6_wd", b_wd[0], 16'h1122);
    end_frame();
    chk("rd_wr_exclusive", both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
